// File: rtl/tap_pkg.sv
// Shared TAP controller types: state encoding, opcode constants and the
// state-to-strobe decode used by the negedge output register.
package tap_pkg;

   typedef enum logic [3:0] {
      ST_EXIT2_DR   = 4'h0,
      ST_EXIT1_DR   = 4'h1,
      ST_SHIFT_DR   = 4'h2,
      ST_PAUSE_DR   = 4'h3,
      ST_SELECT_IR  = 4'h4,
      ST_UPDATE_DR  = 4'h5,
      ST_CAPTURE_DR = 4'h6,
      ST_SELECT_DR  = 4'h7,
      ST_EXIT2_IR   = 4'h8,
      ST_EXIT1_IR   = 4'h9,
      ST_SHIFT_IR   = 4'hA,
      ST_PAUSE_IR   = 4'hB,
      ST_RUN_IDLE   = 4'hC,
      ST_UPDATE_IR  = 4'hD,
      ST_CAPTURE_IR = 4'hE,
      ST_TL_RESET   = 4'hF
   } tap_state_e;

   // Widest legal opcodes; the top truncates them to IR_W bits.
   localparam logic [7:0] TAP_OP_BYPASS = 8'hFF;
   localparam logic [7:0] TAP_OP_IDCODE = 8'h01;

   typedef struct packed {
      logic capture_dr;
      logic shift_dr;
      logic update_dr;
      logic capture_ir;
      logic shift_ir;
      logic update_ir;
      logic tdo_en;
      logic tl_reset;
   } tap_ctl_t;

   function automatic tap_ctl_t tap_ctl_decode(input tap_state_e s);
      tap_ctl_t c;
      c.capture_dr = (s == ST_CAPTURE_DR);
      c.shift_dr   = (s == ST_SHIFT_DR);
      c.update_dr  = (s == ST_UPDATE_DR);
      c.capture_ir = (s == ST_CAPTURE_IR);
      c.shift_ir   = (s == ST_SHIFT_IR);
      c.update_ir  = (s == ST_UPDATE_IR);
      c.tdo_en     = (s == ST_SHIFT_DR) || (s == ST_SHIFT_IR);
      c.tl_reset   = (s == ST_TL_RESET);
      return c;
   endfunction

endpackage

// File: rtl/tap_fsm.sv
// IEEE 1149.1 TAP state machine: posedge state register plus tms-driven
// next-state logic; trst forces Test-Logic-Reset asynchronously.
module tap_fsm
   import tap_pkg::*;
(
   input  logic       tck,
   input  logic       trst,
   input  logic       tms,
   output tap_state_e state_q
);

   tap_state_e state_d;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_TL_RESET:   state_d = tms ? ST_TL_RESET  : ST_RUN_IDLE;
         ST_RUN_IDLE:   state_d = tms ? ST_SELECT_DR : ST_RUN_IDLE;
         ST_SELECT_DR:  state_d = tms ? ST_SELECT_IR : ST_CAPTURE_DR;
         ST_CAPTURE_DR: state_d = tms ? ST_EXIT1_DR  : ST_SHIFT_DR;
         ST_SHIFT_DR:   state_d = tms ? ST_EXIT1_DR  : ST_SHIFT_DR;
         ST_EXIT1_DR:   state_d = tms ? ST_UPDATE_DR : ST_PAUSE_DR;
         ST_PAUSE_DR:   state_d = tms ? ST_EXIT2_DR  : ST_PAUSE_DR;
         ST_EXIT2_DR:   state_d = tms ? ST_UPDATE_DR : ST_SHIFT_DR;
         ST_UPDATE_DR:  state_d = tms ? ST_SELECT_DR : ST_RUN_IDLE;
         ST_SELECT_IR:  state_d = tms ? ST_TL_RESET  : ST_CAPTURE_IR;
         ST_CAPTURE_IR: state_d = tms ? ST_EXIT1_IR  : ST_SHIFT_IR;
         ST_SHIFT_IR:   state_d = tms ? ST_EXIT1_IR  : ST_SHIFT_IR;
         ST_EXIT1_IR:   state_d = tms ? ST_UPDATE_IR : ST_PAUSE_IR;
         ST_PAUSE_IR:   state_d = tms ? ST_EXIT2_IR  : ST_PAUSE_IR;
         ST_EXIT2_IR:   state_d = tms ? ST_UPDATE_IR : ST_SHIFT_IR;
         ST_UPDATE_IR:  state_d = tms ? ST_SELECT_DR : ST_RUN_IDLE;
         default:       state_d = ST_TL_RESET;
      endcase
   end

   always_ff @(posedge tck or posedge trst) begin
      if (trst) state_q <= ST_TL_RESET;
      else      state_q <= state_d;
   end

endmodule

// File: rtl/tap_ctrl_param.sv
// Parameterised JTAG TAP controller with IR, bypass and user-DR selection.
// Define TAP_IDCODE_EN to include the 32-bit IDCODE register.
module tap_ctrl_param
   import tap_pkg::*;
#(
   parameter int          IR_W       = 4,
   parameter int          N_DR       = 2,
   parameter logic [31:0] IDCODE_VAL = 32'h1000_0001
) (
   input  logic            tck,
   input  logic            trst,
   input  logic            tms,
   input  logic            tdi,
   output logic            tdo,
   output logic            tdo_en,
   input  logic [N_DR-1:0] dr_tdo,
   output logic [N_DR-1:0] dr_sel,
   output logic            capture_dr,
   output logic            shift_dr,
   output logic            update_dr,
   output logic            capture_ir,
   output logic            shift_ir,
   output logic            update_ir,
   output logic [IR_W-1:0] instr,
   output logic            tl_reset,
   output logic [3:0]      state
);

   localparam logic [IR_W-1:0] OP_BYPASS  = TAP_OP_BYPASS[IR_W-1:0];
   localparam logic [IR_W-1:0] IR_CAPTURE = IR_W'(1);
`ifdef TAP_IDCODE_EN
   localparam logic [IR_W-1:0] OP_IDCODE  = TAP_OP_IDCODE[IR_W-1:0];
   localparam logic [IR_W-1:0] RST_INSTR  = OP_IDCODE;
`else
   localparam logic [IR_W-1:0] RST_INSTR  = OP_BYPASS;
`endif

   tap_state_e      cur_state;
   logic [IR_W-1:0] ir_sr_q, ir_sr_d;
   logic            bypass_q, bypass_d;
   logic [IR_W-1:0] instr_q, instr_d;
   logic            tdo_q, tdo_d;
   tap_ctl_t        ctl_q, ctl_d;
   logic            sel_idcode;
   logic            id_bit;
   logic            dr_bit;

   tap_fsm u_fsm (
      .tck     (tck),
      .trst    (trst),
      .tms     (tms),
      .state_q (cur_state)
   );

   // Posedge shift paths: IR and bypass follow the state being left.
   always_comb begin
      ir_sr_d  = ir_sr_q;
      bypass_d = bypass_q;
      if (cur_state == ST_CAPTURE_IR)    ir_sr_d = IR_CAPTURE;
      else if (cur_state == ST_SHIFT_IR) ir_sr_d = {tdi, ir_sr_q[IR_W-1:1]};
      if (cur_state == ST_CAPTURE_DR)    bypass_d = 1'b0;
      else if (cur_state == ST_SHIFT_DR) bypass_d = tdi;
   end

   always_ff @(posedge tck or posedge trst) begin
      if (trst) begin
         ir_sr_q  <= IR_CAPTURE;
         bypass_q <= 1'b0;
      end else begin
         ir_sr_q  <= ir_sr_d;
         bypass_q <= bypass_d;
      end
   end

`ifdef TAP_IDCODE_EN
   logic [31:0] id_q, id_d;

   assign sel_idcode = (instr_q == OP_IDCODE);
   assign id_bit     = id_q[0];

   always_comb begin
      id_d = id_q;
      if (sel_idcode && cur_state == ST_CAPTURE_DR)    id_d = IDCODE_VAL;
      else if (sel_idcode && cur_state == ST_SHIFT_DR) id_d = {tdi, id_q[31:1]};
   end

   always_ff @(posedge tck or posedge trst) begin
      if (trst) id_q <= '0;
      else      id_q <= id_d;
   end
`else
   logic unused_idcode;

   // Keeps IDCODE_VAL referenced while the register is compiled out.
   assign unused_idcode = ^IDCODE_VAL;
   assign sel_idcode    = 1'b0;
   assign id_bit        = 1'b0;
`endif

   // Opcode k+2 selects user DR k; anything unmatched falls back to bypass.
   always_comb begin
      dr_sel = '0;
      for (int k = 0; k < N_DR; k++) begin
         if (instr_q == IR_W'(k + 2)) dr_sel[k] = 1'b1;
      end
   end

   always_comb begin
      dr_bit = bypass_q;
      if (sel_idcode) dr_bit = id_bit;
      for (int k = 0; k < N_DR; k++) begin
         if (dr_sel[k]) dr_bit = dr_tdo[k];
      end
   end

   // Negedge outputs: strobes, tdo and the active instruction.
   always_comb begin
      ctl_d   = tap_ctl_decode(cur_state);
      instr_d = instr_q;
      tdo_d   = tdo_q;
      if (cur_state == ST_UPDATE_IR)     instr_d = ir_sr_q;
      else if (cur_state == ST_TL_RESET) instr_d = RST_INSTR;
      if (cur_state == ST_SHIFT_IR)      tdo_d = ir_sr_q[0];
      else if (cur_state == ST_SHIFT_DR) tdo_d = dr_bit;
   end

   always_ff @(negedge tck or posedge trst) begin
      if (trst) begin
         ctl_q   <= tap_ctl_decode(ST_TL_RESET);
         instr_q <= RST_INSTR;
         tdo_q   <= 1'b0;
      end else begin
         ctl_q   <= ctl_d;
         instr_q <= instr_d;
         tdo_q   <= tdo_d;
      end
   end

   assign tdo        = tdo_q;
   assign tdo_en     = ctl_q.tdo_en;
   assign capture_dr = ctl_q.capture_dr;
   assign shift_dr   = ctl_q.shift_dr;
   assign update_dr  = ctl_q.update_dr;
   assign capture_ir = ctl_q.capture_ir;
   assign shift_ir   = ctl_q.shift_ir;
   assign update_ir  = ctl_q.update_ir;
   assign tl_reset   = ctl_q.tl_reset;
   assign instr      = instr_q;
   assign state      = cur_state;

endmodule

// File: tb/tb_tap_ctrl_param.sv
// Directed bench for tap_ctrl_param: reset, IR/DR scans, decode, TLReset paths.
`timescale 1ns/1ps
module tb_tap_ctrl_param;

   localparam int          IR_W       = 4;
   localparam int          N_DR       = 2;
   localparam logic [31:0] IDCODE_VAL = 32'h1000_0001;
`ifdef TAP_IDCODE_EN
   localparam logic [IR_W-1:0] RST_INSTR = 4'h1;
`else
   localparam logic [IR_W-1:0] RST_INSTR = 4'hF;
`endif

   logic            tck = 1'b0;
   logic            trst, tms, tdi;
   logic            tdo, tdo_en;
   logic [N_DR-1:0] dr_tdo, dr_sel;
   logic            capture_dr, shift_dr, update_dr;
   logic            capture_ir, shift_ir, update_ir;
   logic [IR_W-1:0] instr;
   logic            tl_reset;
   logic [3:0]      state;

   int n_checks = 0;
   int n_errors = 0;

   tap_ctrl_param #(.IR_W(IR_W), .N_DR(N_DR), .IDCODE_VAL(IDCODE_VAL)) dut (
      .tck        (tck),
      .trst       (trst),
      .tms        (tms),
      .tdi        (tdi),
      .tdo        (tdo),
      .tdo_en     (tdo_en),
      .dr_tdo     (dr_tdo),
      .dr_sel     (dr_sel),
      .capture_dr (capture_dr),
      .shift_dr   (shift_dr),
      .update_dr  (update_dr),
      .capture_ir (capture_ir),
      .shift_ir   (shift_ir),
      .update_ir  (update_ir),
      .instr      (instr),
      .tl_reset   (tl_reset),
      .state      (state)
   );

   always #5 tck = ~tck;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Apply tms/tdi, take one posedge, then settle just after the negedge.
   task automatic step(input logic t_ms, input logic t_di);
      tms = t_ms;
      tdi = t_di;
      @(posedge tck);
      @(negedge tck);
      #1;
   endtask

   // From Run-Test/Idle: full IR scan back to Run-Test/Idle.
   task automatic scan_ir(input logic [IR_W-1:0] val, output logic [IR_W-1:0] dout, output int upd);
      upd  = 0;
      dout = '0;
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      step(1'b0, 1'b0);
      for (int i = 0; i < IR_W; i++) begin
         dout[i] = tdo;
         step(i == IR_W - 1, val[i]);
      end
      step(1'b1, 1'b0);
      upd += int'(update_ir);
      step(1'b0, 1'b0);
      upd += int'(update_ir);
   endtask

   // From Run-Test/Idle: n-bit DR scan back to Run-Test/Idle.
   task automatic scan_dr(input logic [63:0] din, input int n, output logic [63:0] dout, output int upd);
      upd  = 0;
      dout = '0;
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      step(1'b0, 1'b0);
      for (int i = 0; i < n; i++) begin
         dout[i] = tdo;
         step(i == n - 1, din[i]);
      end
      step(1'b1, 1'b0);
      upd += int'(update_dr);
      step(1'b0, 1'b0);
      upd += int'(update_dr);
   endtask

   initial begin
      logic [IR_W-1:0] ir_out;
      logic [63:0]     dr_out;
      int              upd;
      int              cnt;

      trst   = 1'b0;
      tms    = 1'b1;
      tdi    = 1'b0;
      dr_tdo = 2'b01;
      @(negedge tck);
      #1;

      // Asynchronous reset, checked before any clock edge.
      trst = 1'b1;
      #1;
      check_eq("rst_state", state, 4'hF);
      check_eq("rst_tl_reset", tl_reset, 1'b1);
      check_eq("rst_instr", instr, RST_INSTR);
      check_eq("rst_tdo", tdo, 1'b0);
      check_eq("rst_tdo_en", tdo_en, 1'b0);
      check_eq("rst_dr_sel", dr_sel, 2'b00);
      check_eq("rst_strobes", {capture_dr, shift_dr, update_dr, capture_ir, shift_ir, update_ir}, 6'b0);
      trst = 1'b0;
      step(1'b0, 1'b0);
      check_eq("idle_state", state, 4'hC);
      check_eq("idle_instr", instr, RST_INSTR);
      check_eq("idle_tl_reset", tl_reset, 1'b0);

      // IR scan of 2 selects user DR 0; captured pattern shifts out as 1,0,0,0.
      scan_ir(4'h2, ir_out, upd);
      check_eq("ir2_capture_out", ir_out, 4'b0001);
      check_eq("ir2_instr", instr, 4'h2);
      check_eq("ir2_dr_sel", dr_sel, 2'b01);
      check_eq("ir2_update_ir", upd, 1);
      scan_dr(64'h5, 4, dr_out, upd);
      check_eq("dr0_tdo", dr_out, 64'hF);
      check_eq("dr0_update_dr", upd, 1);

      // User DR 1 sees dr_tdo[1]=0.
      scan_ir(4'h3, ir_out, upd);
      check_eq("ir3_dr_sel", dr_sel, 2'b10);
      scan_dr(64'hA, 4, dr_out, upd);
      check_eq("dr1_tdo", dr_out, 64'h0);

      // Opcode 4 = k 2, outside N_DR: bypass, no select.
      scan_ir(4'h4, ir_out, upd);
      check_eq("ir4_instr", instr, 4'h4);
      check_eq("ir4_dr_sel", dr_sel, 2'b00);
      scan_dr(64'h0A5, 9, dr_out, upd);
      check_eq("ir4_bypass", dr_out, 64'h14A);

      // Opcode 1: IDCODE when enabled, bypass otherwise.
      scan_ir(4'h1, ir_out, upd);
      check_eq("ir1_dr_sel", dr_sel, 2'b00);
      scan_dr(64'hDEAD_BEEF, 32, dr_out, upd);
`ifdef TAP_IDCODE_EN
      check_eq("idcode_out", dr_out, {32'h0, IDCODE_VAL});
`else
      check_eq("op1_bypass", dr_out, (64'hDEAD_BEEF << 1) & 64'hFFFF_FFFF);
`endif

      // Explicit BYPASS opcode.
      scan_ir(4'hF, ir_out, upd);
      check_eq("bypass_instr", instr, 4'hF);
      scan_dr(64'h0A5, 9, dr_out, upd);
      check_eq("bypass_out", dr_out, 64'h14A);

      // From ShiftDR, five tms=1 reach TLReset through UpdateDR.
      scan_ir(4'h2, ir_out, upd);
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      check_eq("capture_dr_strobe", capture_dr, 1'b1);
      step(1'b0, 1'b0);
      check_eq("shift_dr_strobe", shift_dr, 1'b1);
      check_eq("shift_dr_tdo_en", tdo_en, 1'b1);
      cnt = 0;
      for (int i = 0; i < 5; i++) begin
         step(1'b1, 1'b0);
         cnt += int'(update_dr);
      end
      check_eq("tms5_update_dr_count", cnt, 1);
      check_eq("tms5_state", state, 4'hF);
      check_eq("tms5_tl_reset", tl_reset, 1'b1);
      check_eq("tms5_instr", instr, RST_INSTR);
      check_eq("tms5_dr_sel", dr_sel, 2'b00);

      // trst during ShiftIR aborts the scan without an update.
      step(1'b0, 1'b0);
      scan_ir(4'h3, ir_out, upd);
      check_eq("pre_abort_instr", instr, 4'h3);
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      step(1'b0, 1'b0);
      check_eq("abort_shift_ir_before", shift_ir, 1'b1);
      step(1'b0, 1'b1);
      step(1'b0, 1'b0);
      trst = 1'b1;
      #1;
      check_eq("abort_state", state, 4'hF);
      check_eq("abort_instr", instr, RST_INSTR);
      check_eq("abort_tdo_en", tdo_en, 1'b0);
      check_eq("abort_shift_ir", shift_ir, 1'b0);
      check_eq("abort_tdo", tdo, 1'b0);
      cnt = 0;
      step(1'b1, 1'b0);
      cnt += int'(update_ir);
      step(1'b1, 1'b0);
      cnt += int'(update_ir);
      trst = 1'b0;
      step(1'b1, 1'b0);
      cnt += int'(update_ir);
      step(1'b0, 1'b0);
      cnt += int'(update_ir);
      check_eq("abort_no_update_ir", cnt, 0);
      check_eq("abort_final_state", state, 4'hC);
      check_eq("abort_final_instr", instr, RST_INSTR);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
